// File: rtl/mem_rr_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style native memory port.
// m0 (CPU) and m1 (DMA) share one slave port. A grant is held until the slave
// completes, the granted master withdraws, or a hung slave times out.
module mem_rr_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_irq
);

    // Last BUSY cycle index before a forced termination (cnt counts from 0).
    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [15:0] cnt_q;
    logic        timeout_irq_q;

    logic        in_busy;
    logic        gnt_valid;
    logic        complete;
    logic        timeout_hit;
    logic        done;
    logic [31:0] resp_rdata;

    // Decode the granted master's request and the ways a grant can end.
    always_comb begin
        in_busy     = (state_q == StBusy);
        gnt_valid   = grant_q ? m1_valid : m0_valid;
        complete    = in_busy && gnt_valid && s_ready;
        timeout_hit = in_busy && gnt_valid && !s_ready && (cnt_q == CntLast);
        done        = complete || timeout_hit;
        resp_rdata  = complete ? s_rdata : ERR_RDATA;
    end

    // Slave-side mux; everything is zero outside BUSY.
    always_comb begin
        s_valid = 1'b0;
        s_wstrb = 4'h0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        if (in_busy) begin
            // The timeout force is the only s_ready -> s_valid dependency.
            s_valid = gnt_valid && !timeout_hit;
            if (grant_q) begin
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    // Master-side responses: only the granted master ever sees ready/rdata.
    always_comb begin
        m0_ready = done && !grant_q;
        m1_ready = done && grant_q;
        m0_rdata = m0_ready ? resp_rdata : 32'h0;
        m1_rdata = m1_ready ? resp_rdata : 32'h0;
    end

    // Arbitration FSM with grant history, timeout counter and irq pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;  // m0 wins the first tie
            cnt_q         <= 16'h0;
            timeout_irq_q <= 1'b0;
        end else begin
            timeout_irq_q <= timeout_hit;
            unique case (state_q)
                StIdle: begin
                    if (m0_valid || m1_valid) begin
                        if (m0_valid && m1_valid) begin
                            grant_q <= ~last_grant_q;
                        end else begin
                            grant_q <= m1_valid;
                        end
                        cnt_q   <= 16'h0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!gnt_valid) begin
                        // Withdrawn request: no response, history untouched.
                        state_q <= StIdle;
                    end else if (done) begin
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = in_busy;
    assign timeout_irq = timeout_irq_q;

endmodule
